// File: rtl/raster_pkg.sv
// raster_pkg: shared scheduler state and coordinate types
package raster_pkg;
    localparam int COORD_WIDTH = 10;
    typedef logic signed [COORD_WIDTH-1:0] coord_t;
    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} sched_state_t;
endpackage

// File: rtl/bounding_box.sv
// bounding_box: triangle bounding box clipped to a half-open tile
module bounding_box #(
    parameter int TILE_MIN_X = 0,
    parameter int TILE_MAX_X = 32,
    parameter int TILE_MIN_Y = 0,
    parameter int TILE_MAX_Y = 16,
    parameter int COORD_WIDTH = 10
) (
    input  logic signed [COORD_WIDTH-1:0] x0,
    input  logic signed [COORD_WIDTH-1:0] y0,
    input  logic signed [COORD_WIDTH-1:0] x1,
    input  logic signed [COORD_WIDTH-1:0] y1,
    input  logic signed [COORD_WIDTH-1:0] x2,
    input  logic signed [COORD_WIDTH-1:0] y2,
    output logic signed [COORD_WIDTH-1:0] min_x,
    output logic signed [COORD_WIDTH-1:0] max_x,
    output logic signed [COORD_WIDTH-1:0] min_y,
    output logic signed [COORD_WIDTH-1:0] max_y
);
    localparam logic signed [COORD_WIDTH-1:0] LX = TILE_MIN_X[COORD_WIDTH-1:0];
    localparam logic signed [COORD_WIDTH-1:0] HX = TILE_MAX_X[COORD_WIDTH-1:0];
    localparam logic signed [COORD_WIDTH-1:0] LY = TILE_MIN_Y[COORD_WIDTH-1:0];
    localparam logic signed [COORD_WIDTH-1:0] HY = TILE_MAX_Y[COORD_WIDTH-1:0];

    function automatic logic signed [COORD_WIDTH-1:0] mn(input logic signed [COORD_WIDTH-1:0] a, input logic signed [COORD_WIDTH-1:0] b);
        return a < b ? a : b;
    endfunction

    function automatic logic signed [COORD_WIDTH-1:0] mx(input logic signed [COORD_WIDTH-1:0] a, input logic signed [COORD_WIDTH-1:0] b);
        return a > b ? a : b;
    endfunction

    // vertex maxima act as exclusive edges, matching the tile's own half-open bounds
    assign min_x = mx(mn(mn(x0, x1), x2), LX);
    assign max_x = mn(mx(mx(x0, x1), x2), HX);
    assign min_y = mx(mn(mn(y0, y1), y2), LY);
    assign max_y = mn(mx(mx(y0, y1), y2), HY);
endmodule

// File: rtl/tile_raster_scheduler.sv
// tile_raster_scheduler: walks the clipped triangle bbox in raster order, one pixel per handshake
module tile_raster_scheduler import raster_pkg::*; #(
    parameter int TILE_MIN_X = 0,
    parameter int TILE_MAX_X = 32,
    parameter int TILE_MIN_Y = 0,
    parameter int TILE_MAX_Y = 16,
    parameter int COORD_WIDTH = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tri_valid,
    output logic tri_ready,
    input  logic signed [COORD_WIDTH-1:0] x0,
    input  logic signed [COORD_WIDTH-1:0] y0,
    input  logic signed [COORD_WIDTH-1:0] x1,
    input  logic signed [COORD_WIDTH-1:0] y1,
    input  logic signed [COORD_WIDTH-1:0] x2,
    input  logic signed [COORD_WIDTH-1:0] y2,
    input  logic abort,
    output logic pix_valid,
    input  logic pix_ready,
    output logic signed [COORD_WIDTH-1:0] pix_x,
    output logic signed [COORD_WIDTH-1:0] pix_y,
    output logic pix_last,
    output logic tri_done,
    output logic tri_empty,
    output logic busy
);
    typedef logic signed [COORD_WIDTH-1:0] crd_t;
    typedef logic signed [COORD_WIDTH:0] wide_t;

    sched_state_t state, state_nx;
    crd_t vx0, vy0, vx1, vy1, vx2, vy2;
    crd_t bx0, bx1, by0, by1;
    crd_t min_x, max_x, min_y, max_y;
    logic empty_q, tri_hs, pix_hs, x_end, y_end, area;

    bounding_box #(
        .TILE_MIN_X(TILE_MIN_X), .TILE_MAX_X(TILE_MAX_X),
        .TILE_MIN_Y(TILE_MIN_Y), .TILE_MAX_Y(TILE_MAX_Y),
        .COORD_WIDTH(COORD_WIDTH)
    ) u_bbox (
        .x0(vx0), .y0(vy0), .x1(vx1), .y1(vy1), .x2(vx2), .y2(vy2),
        .min_x(bx0), .max_x(bx1), .min_y(by0), .max_y(by1)
    );

    always_comb begin
        // one extra bit keeps x+1 from wrapping when an edge sits at the signed maximum
        x_end = wide_t'(pix_x) + wide_t'(1) == wide_t'(max_x);
        y_end = wide_t'(pix_y) + wide_t'(1) == wide_t'(max_y);
        area = bx0 < bx1 && by0 < by1;
        tri_ready = state == IDLE && !rst;
        busy = state != IDLE;
        pix_valid = state == SCAN;
        pix_last = pix_valid && x_end && y_end;
        tri_done = state == DONE;
        tri_empty = tri_done && empty_q;
        tri_hs = tri_valid && tri_ready;
        pix_hs = pix_valid && pix_ready;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = tri_hs ? SETUP : IDLE;
            SETUP:   state_nx = abort ? IDLE : area ? SCAN : DONE;
            SCAN:    state_nx = abort ? IDLE : pix_hs && pix_last ? DONE : SCAN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pix_x <= '0;
            pix_y <= '0;
            empty_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (tri_hs) begin
                vx0 <= x0;
                vy0 <= y0;
                vx1 <= x1;
                vy1 <= y1;
                vx2 <= x2;
                vy2 <= y2;
            end
            if (state == SETUP) begin
                min_x <= bx0;
                max_x <= bx1;
                min_y <= by0;
                max_y <= by1;
                pix_x <= bx0;
                pix_y <= by0;
                empty_q <= !area;
            end
            if (pix_hs && !abort && !pix_last) begin
                pix_x <= x_end ? min_x : pix_x + crd_t'(1);
                if (x_end) pix_y <= pix_y + crd_t'(1);
            end
        end
    end
endmodule

// File: tb/tb_tile_raster_scheduler.sv
// tb_tile_raster_scheduler: scoreboard bench for the tile raster scheduler
module tb_tile_raster_scheduler;
    logic clk = 0;
    logic rst, tri_valid, abort, pix_ready;
    logic signed [9:0] x0, y0, x1, y1, x2, y2, pix_x, pix_y;
    logic tri_ready, pix_valid, pix_last, tri_done, tri_empty, busy;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic signed [9:0] x;
        logic signed [9:0] y;
        logic last;
    } pix_t;

    pix_t q[$];
    logic exp_empty;

    always #5 clk = ~clk;

    tile_raster_scheduler dut (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .abort(abort), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .tri_done(tri_done), .tri_empty(tri_empty), .busy(busy)
    );

    function automatic int imin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_model(input int ax, input int ay, input int bx, input int by, input int cx, input int cy);
        int mnx, mxx, mny, mxy;
        pix_t p;
        mnx = imax(imin(imin(ax, bx), cx), 0);
        mxx = imin(imax(imax(ax, bx), cx), 32);
        mny = imax(imin(imin(ay, by), cy), 0);
        mxy = imin(imax(imax(ay, by), cy), 16);
        q.delete();
        for (int y = mny; y < mxy; y++)
            for (int x = mnx; x < mxx; x++) begin
                p.x = 10'(x);
                p.y = 10'(y);
                p.last = x == mxx - 1 && y == mxy - 1;
                q.push_back(p);
            end
        exp_empty = !(mnx < mxx && mny < mxy);
    endtask

    task automatic send_tri(input int ax, input int ay, input int bx, input int by, input int cx, input int cy);
        int n = 0;
        load_model(ax, ay, bx, by, cx, cy);
        while (!tri_ready && n < 50) begin
            step;
            n++;
        end
        checks++;
        if (tri_ready !== 1'b1) begin
            errors++;
            $display("FAIL tri_ready_wait: tri_ready=%b required 1", tri_ready);
        end
        tri_valid = 1;
        x0 = 10'(ax); y0 = 10'(ay); x1 = 10'(bx); y1 = 10'(by); x2 = 10'(cx); y2 = 10'(cy);
        step;
        tri_valid = 0;
        x0 = 10'($urandom); y0 = 10'($urandom); x1 = 10'($urandom);
        y1 = 10'($urandom); x2 = 10'($urandom); y2 = 10'($urandom);
    endtask

    task automatic run_tri(input bit rnd);
        int n = 1;
        int first = -1;
        bit stalled = 0;
        bit done = 0;
        pix_t prev, cur;
        prev = '0;
        while (!done && n < 3000) begin
            cur = '{pix_x, pix_y, pix_last};
            if (stalled) begin
                checks++;
                if ({pix_valid, cur} !== {1'b1, prev}) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b (%0d,%0d,%b) required 1 (%0d,%0d,%b)",
                             pix_valid, cur.x, cur.y, cur.last, prev.x, prev.y, prev.last);
                end
            end
            if (pix_valid) begin
                if (first < 0) begin
                    first = n;
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_scan: busy=%b required 1", busy);
                    end
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pixel: got (%0d,%0d) required none", cur.x, cur.y);
                end else if (cur !== q[0]) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                             cur.x, cur.y, cur.last, q[0].x, q[0].y, q[0].last);
                end
            end
            if (tri_done) begin
                done = 1;
                checks++;
                if (tri_empty !== exp_empty) begin
                    errors++;
                    $display("FAIL tri_empty: got %b required %b", tri_empty, exp_empty);
                end
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL pixel_count: %0d pixels missing required 0", q.size());
                end
                checks++;
                if ((exp_empty ? n : first) != 2 || (exp_empty && first >= 0)) begin
                    errors++;
                    $display("FAIL latency: done_cycle=%0d first_pix=%0d required 2", n, first);
                end
            end else begin
                pix_ready = rnd ? 1'($urandom) : 1'b1;
                if (pix_valid && pix_ready && q.size() > 0) void'(q.pop_front());
                stalled = pix_valid && !pix_ready;
                prev = cur;
                step;
                n++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no tri_done after %0d cycles required done", n);
        end
        step;
        checks++;
        if ({tri_ready, tri_done, pix_valid} !== 3'b100) begin
            errors++;
            $display("FAIL post_done: ready/done/valid=%b%b%b required 100", tri_ready, tri_done, pix_valid);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({tri_ready, pix_valid, pix_last, tri_done, tri_empty, busy, pix_x, pix_y} !== 26'd0) begin
            errors++;
            $display("FAIL %s: ready=%b valid=%b last=%b done=%b empty=%b busy=%b x=%0d y=%0d required all 0",
                     name, tri_ready, pix_valid, pix_last, tri_done, tri_empty, busy, pix_x, pix_y);
        end
    endtask

    task automatic test_reset;
        rst = 1; tri_valid = 1; abort = 1; pix_ready = 1;
        x0 = 1; y0 = 1; x1 = 4; y1 = 1; x2 = 1; y2 = 3;
        step;
        step;
        check_zero("reset_outputs");
        rst = 0; tri_valid = 0; abort = 0;
        step;
        checks++;
        if ({tri_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ready/busy=%b%b required 10", tri_ready, busy);
        end
    endtask

    task automatic test_basic;
        send_tri(1, 1, 4, 1, 1, 3);
        run_tri(0);
    endtask

    task automatic test_clip;
        send_tri(-5, -5, 40, -5, -5, 20);
        checks++;
        if (q.size() != 512 || q[511] !== pix_t'({10'sd31, 10'sd15, 1'b1})) begin
            errors++;
            $display("FAIL clip_model: %0d pixels required 512", q.size());
        end
        run_tri(0);
    endtask

    task automatic test_empty;
        send_tri(3, 2, 3, 9, 3, 5);
        run_tri(0);
    endtask

    task automatic test_stall;
        send_tri(1, 1, 4, 1, 1, 3);
        run_tri(1);
    endtask

    task automatic test_abort;
        pix_t cur;
        send_tri(1, 1, 4, 1, 1, 3);
        pix_ready = 1;
        step;
        step;
        step;
        cur = '{pix_x, pix_y, pix_last};
        checks++;
        if ({pix_valid, cur} !== {1'b1, 10'sd3, 10'sd1, 1'b0}) begin
            errors++;
            $display("FAIL abort_pending: valid=%b (%0d,%0d) required 1 (3,1)", pix_valid, cur.x, cur.y);
        end
        abort = 1;
        step;
        abort = 0;
        checks++;
        if ({pix_valid, tri_ready, tri_done} !== 3'b010) begin
            errors++;
            $display("FAIL abort_effect: valid/ready/done=%b%b%b required 010", pix_valid, tri_ready, tri_done);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (tri_done !== 1'b0 || pix_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: done=%b valid=%b required 0 0", tri_done, pix_valid);
            end
        end
        test_basic();
    endtask

    task automatic test_reset_mid;
        send_tri(-5, -5, 40, -5, -5, 20);
        pix_ready = 1;
        repeat (5) step;
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan: pix_valid=%b required 1", pix_valid);
        end
        rst = 1; abort = 1;
        step;
        check_zero("reset_mid_outputs");
        rst = 0; abort = 0;
        step;
        checks++;
        if ({tri_ready, tri_done, pix_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_release: ready/done/valid/busy=%b%b%b%b required 1000",
                     tri_ready, tri_done, pix_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        send_tri(1, 1, 4, 1, 1, 3);
        run_tri(0);
        send_tri(2, 0, 5, 2, 2, 2);
        run_tri(1);
        send_tri(3, 2, 3, 9, 3, 5);
        run_tri(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
